decoded_word_uart_framer: RTL

//  Downstream readout stage of the receiver top level.

---
 rtl/rx_readout_pkg.sv | 23 ++
 rtl/word_fifo.sv | 56 +++++
 rtl/decoded_word_uart_framer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rx_readout_pkg.sv
// Shared types for the receiver readout stage: framer states and frame geometry.
package rx_readout_pkg;

    typedef enum logic [3:0] {
        IDLE, LOAD, SYNC, SEQ, D3, D2, D1, D0, CHK, GAP
    } framer_state_t;

    localparam int FRAME_BYTES = 7;

    // Byte state that follows a given byte state; the checksum closes the frame.
    function automatic framer_state_t next_byte_state(input framer_state_t s);
        case (s)
            SYNC:    return SEQ;
            SEQ:     return D3;
            D3:      return D2;
            D2:      return D1;
            D1:      return D0;
            D0:      return CHK;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with first-word-fall-through read data and a registered fill level.
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_reg == (AW+1)'(DEPTH));
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign pop_data = mem[rd_ptr_reg];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/decoded_word_uart_framer.sv
// Buffers decoded words and streams each one to the UART as a 7-byte frame
// (sync, sequence, data MSB first, XOR checksum) over a valid/ready handshake.
module decoded_word_uart_framer
    import rx_readout_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          GAP_CYCLES = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                           CLOCK_50,
    input  logic                           reset_n,
    input  logic [31:0]                    buffer,
    input  logic                           buffer_valid,
    input  logic                           tx_data_ready,
    output logic [7:0]                     tx_data,
    output logic                           tx_data_valid,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           overflow,
    output logic                           frame_busy
);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    logic           valid_prev_reg;
    logic           capture_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [31:0]    fifo_data;
    logic           overflow_reg;
    logic           accept;

    framer_state_t  state_reg, state_next;
    framer_state_t  ret_state_reg, ret_state_next;
    logic [GW-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [7:0]     seq_reg, seq_next;
    logic [7:0]     chk_reg, chk_next;
    logic [31:0]    word_reg, word_next;
    logic [7:0]     tx_data_reg, tx_data_next;
    logic           tx_valid_reg, tx_valid_next;

    assign capture_push = buffer_valid & ~valid_prev_reg;
    assign accept       = tx_valid_reg & tx_data_ready;

    word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLOCK_50),
        .reset_n   (reset_n),
        .push      (capture_push),
        .push_data (buffer),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_next     = state_reg;
        ret_state_next = ret_state_reg;
        gap_cnt_next   = gap_cnt_reg;
        seq_next       = seq_reg;
        chk_next       = chk_reg;
        word_next      = word_reg;
        fifo_pop       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    word_next  = fifo_data;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                chk_next   = seq_reg ^ word_reg[31:24] ^ word_reg[23:16]
                           ^ word_reg[15:8] ^ word_reg[7:0];
                state_next = SYNC;
            end
            GAP: begin
                if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) begin
                    state_next = ret_state_reg;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (state_reg == CHK) seq_next = seq_reg + 8'd1;
                    if (GAP_CYCLES > 0) begin
                        state_next     = GAP;
                        ret_state_next = next_byte_state(state_reg);
                        gap_cnt_next   = '0;
                    end else begin
                        state_next = next_byte_state(state_reg);
                    end
                end
            end
        endcase

        // Output byte follows the state being entered, so tx_data holds steady under backpressure.
        tx_valid_next = state_next inside {SYNC, SEQ, D3, D2, D1, D0, CHK};
        case (state_next)
            SYNC:    tx_data_next = SYNC_BYTE;
            SEQ:     tx_data_next = seq_reg;
            D3:      tx_data_next = word_reg[31:24];
            D2:      tx_data_next = word_reg[23:16];
            D1:      tx_data_next = word_reg[15:8];
            D0:      tx_data_next = word_reg[7:0];
            CHK:     tx_data_next = chk_reg;
            default: tx_data_next = 8'h00;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            valid_prev_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            state_reg      <= IDLE;
            ret_state_reg  <= IDLE;
            gap_cnt_reg    <= '0;
            seq_reg        <= 8'h00;
            chk_reg        <= 8'h00;
            word_reg       <= 32'h0;
            tx_data_reg    <= 8'h00;
            tx_valid_reg   <= 1'b0;
        end else begin
            valid_prev_reg <= buffer_valid;
            if (capture_push && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
            state_reg      <= state_next;
            ret_state_reg  <= ret_state_next;
            gap_cnt_reg    <= gap_cnt_next;
            seq_reg        <= seq_next;
            chk_reg        <= chk_next;
            word_reg       <= word_next;
            tx_data_reg    <= tx_data_next;
            tx_valid_reg   <= tx_valid_next;
        end
    end

    assign tx_data       = tx_data_reg;
    assign tx_data_valid = tx_valid_reg;
    assign overflow      = overflow_reg;
    assign frame_busy    = (state_reg != IDLE);

endmodule
